// File: rtl/radar_det_streamer.sv
// Multi-channel CFAR detection streamer: per-channel holding registers, round-robin into a FIFO,
// per-CPI trailer beats on AXI4-Stream. Optional statistics enabled by RADAR_DSTREAM_STATS_EN.
module radar_det_streamer #(
    parameter int NUM_CH     = 4,
    parameter int RANGE_W    = 16,
    parameter int VEL_W      = 16,
    parameter int FIFO_DEPTH = 64,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          det_valid,
    input  logic [NUM_CH*RANGE_W-1:0]  det_range,
    input  logic [NUM_CH*VEL_W-1:0]    det_velocity,
    input  logic                       cpi_end,
    input  logic                       clear_status,
    output logic [RANGE_W+VEL_W-1:0]   m_axis_tdata,
    output logic [CH_W:0]              m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       frame_done_irq,
    output logic [LVL_W-1:0]           fifo_level,
    output logic [15:0]                drop_count,
    output logic                       cpi_overrun
);

    localparam int DW = RANGE_W + VEL_W;
    localparam int EW = 1 + CH_W + DW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input logic [CH_W:0] inc);
        logic [CH_W:0] s;
        s = {1'b0, base} + inc;
        if (s >= NCH) s = s - NCH;
        return s[CH_W-1:0];
    endfunction

    logic [NUM_CH-1:0]  r_h_vld;
    logic [NUM_CH-1:0]  r_h_epoch;
    logic [RANGE_W-1:0] r_h_range [NUM_CH];
    logic [VEL_W-1:0]   r_h_vel   [NUM_CH];
    logic               r_cap_epoch;
    logic               r_wr_epoch;
    logic               r_eop_pending;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [RANGE_W-1:0] r_det_count;
    logic [VEL_W-1:0]   r_cpi_seq;

    logic [EW-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW:0]        r_mcnt;
    logic [LVL_W-1:0]   r_level;
    logic               r_ovld;
    logic [EW-1:0]      r_oent;
    logic               r_irq;

    logic [NUM_CH-1:0]  w_elig;
    logic               w_gnt_any;
    logic [CH_W-1:0]    w_gnt_idx;
    logic [NUM_CH-1:0]  w_gnt;
    logic [NUM_CH-1:0]  w_drop;
    logic               w_full;
    logic               w_wr_det;
    logic               w_wr_trl;
    logic               w_wr;
    logic [EW-1:0]      w_wentry;
    logic               w_hs;
    logic               w_pop;
    logic               w_cpi_acc;
    logic               w_cpi_ovr;

    // Only data from the CPI currently being written may compete; later-epoch data waits for the trailer.
    assign w_elig    = r_h_vld & ~(r_h_epoch ^ {NUM_CH{r_wr_epoch}});
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_wr_det  = w_gnt_any && !w_full;
    assign w_wr_trl  = r_eop_pending && (w_elig == '0) && !w_full;
    assign w_wr      = w_wr_det || w_wr_trl;
    assign w_cpi_acc = enable && cpi_end && !r_eop_pending;
    assign w_cpi_ovr = enable && cpi_end && r_eop_pending;
    assign w_hs      = r_ovld && m_axis_tready;
    assign w_pop     = (r_mcnt != '0) && (!r_ovld || w_hs);

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_gnt_any && w_elig[wrap_add(r_rr_ptr, (CH_W+1)'(k))]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = wrap_add(r_rr_ptr, (CH_W+1)'(k));
            end
        end
    end

    always_comb begin
        w_gnt  = '0;
        w_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_gnt[i]  = w_wr_det && (w_gnt_idx == CH_W'(i));
            w_drop[i] = enable && det_valid[i] && r_h_vld[i] && !w_gnt[i];
        end
    end

    always_comb begin
        w_wentry = {1'b0, w_gnt_idx, r_h_vel[w_gnt_idx], r_h_range[w_gnt_idx]};
        if (w_wr_trl) w_wentry = {1'b1, {CH_W{1'b0}}, r_cpi_seq, r_det_count};
    end

    // Capture stage: a holding register reloads in the same cycle it is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_vld   <= '0;
            r_h_epoch <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_h_range[i] <= '0;
                r_h_vel[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (enable && det_valid[i] && (!r_h_vld[i] || w_gnt[i])) begin
                    r_h_vld[i]   <= 1'b1;
                    r_h_epoch[i] <= r_cap_epoch;
                    r_h_range[i] <= det_range[i*RANGE_W +: RANGE_W];
                    r_h_vel[i]   <= det_velocity[i*VEL_W +: VEL_W];
                end else if (w_gnt[i]) begin
                    r_h_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_epoch   <= 1'b0;
            r_wr_epoch    <= 1'b0;
            r_eop_pending <= 1'b0;
            r_rr_ptr      <= '0;
            r_det_count   <= '0;
            r_cpi_seq     <= '0;
        end else begin
            if (w_cpi_acc) begin
                r_cap_epoch   <= ~r_cap_epoch;
                r_eop_pending <= 1'b1;
            end
            if (w_wr_det) begin
                r_rr_ptr <= wrap_add(w_gnt_idx, (CH_W+1)'(1));
                if (r_det_count != '1) r_det_count <= r_det_count + 1'b1;
            end
            if (w_wr_trl) begin
                r_wr_epoch    <= ~r_wr_epoch;
                r_eop_pending <= 1'b0;
                r_det_count   <= '0;
                r_cpi_seq     <= r_cpi_seq + 1'b1;
            end
        end
    end

    // FIFO write stage
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_wentry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_mcnt  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_mcnt <= r_mcnt + 1'b1;
                2'b01:   r_mcnt <= r_mcnt - 1'b1;
                default: r_mcnt <= r_mcnt;
            endcase
            case ({w_wr, w_hs})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Output register stage: contents only change on load, so they hold until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovld <= 1'b0;
            r_oent <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ovld <= 1'b1;
                r_oent <= r_mem[r_rptr];
            end else if (w_hs) begin
                r_ovld <= 1'b0;
            end
            r_irq <= w_hs && r_oent[EW-1];
        end
    end

    assign m_axis_tvalid  = r_ovld;
    assign m_axis_tdata   = r_oent[DW-1:0];
    assign m_axis_tuser   = r_oent[EW-1:DW];
    assign m_axis_tlast   = r_ovld && r_oent[EW-1];
    assign frame_done_irq = r_irq;
    assign fifo_level     = r_level;

`ifdef RADAR_DSTREAM_STATS_EN
    logic [15:0] r_drop_cnt;
    logic        r_overrun;
    logic [4:0]  w_drop_n;
    logic [16:0] w_drop_sum;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NUM_CH; i++) w_drop_n = w_drop_n + 5'(w_drop[i]);
    end
    assign w_drop_sum = {1'b0, r_drop_cnt} + {12'b0, w_drop_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_overrun  <= 1'b0;
        end else if (clear_status) begin
            r_drop_cnt <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_cpi_ovr) r_overrun <= 1'b1;
        end
    end

    assign drop_count  = r_drop_cnt;
    assign cpi_overrun = r_overrun;
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{w_drop, w_cpi_ovr, clear_status};
    assign drop_count     = '0;
    assign cpi_overrun    = 1'b0;
`endif

endmodule

// File: doc/radar_det_streamer.md
# radar_det_streamer

Multi-channel detection report streamer between the per-channel CFAR detectors and the DMA's AXI4-Stream input. It collects range/velocity detections from NUM_CH channels, arbitrates them round-robin into a buffer FIFO, and closes every CPI with a trailer beat carrying the detection count and CPI sequence number. Output uses full tvalid/tready handshaking, and tlast marks CPI boundaries.

## Interface
- NUM_CH, 4: detector channels, 1–16.
- RANGE_W, 16: range field width.
- VEL_W, 16: velocity field width.
- FIFO_DEPTH, 64: buffer entries, power of two, 4 or more.
- CH_W, derived: max(1, $clog2(NUM_CH)).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  accept detections and cpi_end; when low both are ignored and the FIFO keeps draining.
- det_valid  in  NUM_CH  per-channel detection strobe.
- det_range  in  NUM_CH*RANGE_W  packed ranges; channel i at [i*RANGE_W +: RANGE_W].
- det_velocity  in  NUM_CH*VEL_W  packed velocities.
- cpi_end  in  1  one-cycle end-of-CPI pulse.
- clear_status  in  1  clears drop_count and cpi_overrun.
- m_axis_tdata  out  RANGE_W+VEL_W  detection: {velocity, range}; trailer: {cpi_seq, det_count}.
- m_axis_tuser  out  CH_W+1  {is_trailer, channel}; channel is 0 on trailers.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tlast  out  1  high only on trailer beats.
- frame_done_irq  out  1  one-cycle pulse when a trailer beat handshakes.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries, including the output register.

## Operation
- Per channel: one holding register {valid, epoch, range, velocity}.
- Capture: when det_valid[i] and enable are high, the holding register loads if it is empty or is granted in the same cycle. Otherwise the new detection is dropped.
- capture_epoch toggles on an accepted cpi_end. A detection in the same cycle as cpi_end takes the old epoch.
- Arbiter: at most one FIFO write per cycle. Only holding registers whose epoch equals write_epoch are eligible, and only when the FIFO is not full. Selection is round-robin, starting at rr_ptr. After a grant, rr_ptr becomes the granted index + 1, mod NUM_CH. rr_ptr resets to 0.
- Trailer: when eop_pending is set and no holding register holds write_epoch data, the trailer is written (FIFO not full). On that write:
  - write_epoch toggles and eop_pending clears.
  - det_count resets to 0.
  - cpi_seq increments, wrapping at 2^VEL_W.
- det_count increments on each detection write and saturates at 2^RANGE_W−1.
- An accepted cpi_end sets eop_pending. A cpi_end while eop_pending is already set is ignored and sets cpi_overrun (sticky).
- A CPI with no detections still emits a trailer with det_count = 0.
- drop_count (16 bits) saturates. If a drop and clear_status occur in the same cycle, clear wins.
- The FIFO head is presented on a registered output stage. A beat leaves only on tvalid && tready.
- While tvalid is high, tdata, tuser and tlast hold stable until the handshake.

## Timing
- Reset values:
  - m_axis_tvalid, m_axis_tlast, frame_done_irq: 0.
  - m_axis_tdata, m_axis_tuser, fifo_level, drop_count: 0.
  - cpi_overrun: 0.
  - Holding registers, FIFO, epochs, rr_ptr, cpi_seq, det_count: cleared.
- Latency with the block idle and tready high: det_valid sampled at edge 0, FIFO written at edge 1, m_axis_tvalid high after edge 2.
- Throughput: one beat per cycle sustained.
- FIFO full: no writes; holding registers stall and further detections on stalled channels drop.
- FIFO empty with tready high: tvalid stays low. tvalid never depends combinationally on tready.
- frame_done_irq asserts in the cycle after the trailer handshake.
- Reset mid-frame: everything in flight is discarded. The first trailer after reset carries cpi_seq = 0.

## Configuration
- RADAR_DSTREAM_STATS_EN defined: drop_count, cpi_overrun and clear_status are functional as described.
- Macro undefined: the counter and sticky flag logic is removed. drop_count and cpi_overrun are tied to 0, and clear_status is ignored. Drop and overrun behaviour on the datapath is unchanged.

## Test plan
- Single detection: ch2, range 0x0123, velocity 0x0045, then cpi_end, tready held 1. Expect a beat with tdata 0x00450123, tuser {0,2}, tlast 0, tvalid two cycles after det_valid. Then a trailer with tdata 0x00000001, tuser {1,0}, tlast 1, and frame_done_irq one cycle after it.
- Simultaneous strobe: all 4 channels in one cycle. Expect channel order 0,1,2,3. Repeat with rr_ptr = 2: expect order 2,3,0,1.
- Empty CPIs: two cpi_end pulses 10 cycles apart with no detections. Expect trailers 0x00000000, then 0x00010000.
- Backpressure: tready = 0 while 70 detections arrive on ch0 across CPIs. Expect fifo_level = FIFO_DEPTH and drop_count incrementing. Raise tready: no beat lost or duplicated, and ordering preserved.
- Epoch split: ch1 is stalled by a full FIFO, cpi_end arrives, then a new ch1 detection is attempted. Expect the old detection to precede the trailer, the new detection to be dropped (drop_count +1), and a second cpi_end before the trailer to set cpi_overrun.
- Reset mid-frame: assert rst_n low with 5 beats buffered. Expect all outputs 0 immediately, and the next trailer to carry cpi_seq 0.
